// File: rtl/axi_ctrl_pkg.sv
// Shared definitions for the AXI ring reader.
// Holds the reader FSM state encoding, the fixed AXI burst constants,
// and a helper that derives AXI AxSIZE from a bus width in bytes.
package axi_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAr   = 2'd1,
        StR    = 2'd2,
        StOut  = 2'd3
    } state_e;

    localparam logic [7:0] AxiLenSingle = 8'd0;
    localparam logic [1:0] AxiBurstIncr = 2'b01;
    localparam logic [3:0] AxiCacheNone = 4'd0;
    localparam logic [2:0] AxiProtNone  = 3'd0;

    // AxSIZE is log2 of the number of bytes per beat.
    function automatic logic [2:0] axi_size(input int unsigned bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/axi_ring_reader.sv
// Ring buffer reader: fetches one DATA_WIDTH entry at a time over AXI
// read (single-beat bursts) from a ring at base_addr and forwards each
// entry as a one-beat AXI-Stream packet.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   enable               permits new reads
//   base_addr, wr_ptr    ring base byte address, producer index
//   rd_ptr, rd_err       consumer index, sticky read-error flag
//   m_axi_ar*, m_axi_r*  AXI read address / data channels
//   m_axis_t*            AXI-Stream output
module axi_ring_reader
    import axi_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ADDR_WIDTH = 34,
    parameter int unsigned ID_WIDTH   = 6,
    parameter int unsigned FIFO_DEPTH = 32,
    localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [PTR_WIDTH-1:0]  wr_ptr,
    output logic [PTR_WIDTH-1:0]  rd_ptr,
    output logic                  rd_err,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    state_e                state_q, state_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic                  rd_err_q, rd_err_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_inc;
    logic                  ring_empty;

    // rid/rlast carry no information with one single-beat read in flight.
    logic unused_r;
    assign unused_r = ^{m_axi_rid, m_axi_rlast};

    assign ring_empty = (rd_ptr_q == wr_ptr);
    assign rd_ptr_inc = (rd_ptr_q == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rd_err_d  = rd_err_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        unique case (state_q)
            StIdle: begin
                if (enable && !ring_empty) begin
                    araddr_d  = base_addr + ADDR_WIDTH'(rd_ptr_q) * ADDR_WIDTH'(KEEP_WIDTH);
                    arvalid_d = 1'b1;
                    state_d   = StAr;
                end
            end
            StAr: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = StR;
                end
            end
            StR: begin
                if (m_axi_rvalid) begin
                    tdata_d  = m_axi_rdata;
                    tvalid_d = 1'b1;
                    rd_err_d = rd_err_q | (m_axi_rresp != 2'b00);
                    state_d  = StOut;
                end
            end
            StOut: begin
                if (m_axis_tready) begin
                    tvalid_d = 1'b0;
                    rd_ptr_d = rd_ptr_inc;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rd_ptr_q  <= '0;
            rd_err_q  <= 1'b0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_err_q  <= rd_err_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
        end
    end

    assign rd_ptr        = rd_ptr_q;
    assign rd_err        = rd_err_q;

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = AxiLenSingle;
    assign m_axi_arsize  = axi_size(KEEP_WIDTH);
    assign m_axi_arburst = AxiBurstIncr;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = AxiCacheNone;
    assign m_axi_arprot  = AxiProtNone;
    assign m_axi_arvalid = arvalid_q;

    assign m_axi_rready  = (state_q == StR);

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = '1;
    assign m_axis_tlast  = 1'b1;
    assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axi_ring_reader.sv
// Directed self-checking bench for axi_ring_reader (default parameters:
// 512-bit data, 64-byte entries, 32-entry ring, 34-bit addresses).
module tb_axi_ring_reader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [33:0]  base_addr;
    logic [4:0]   wr_ptr;
    logic [4:0]   rd_ptr;
    logic         rd_err;
    logic [5:0]   m_axi_arid;
    logic [33:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arlock;
    logic [3:0]   m_axi_arcache;
    logic [2:0]   m_axi_arprot;
    logic         m_axi_arvalid;
    logic         m_axi_arready;
    logic [5:0]   m_axi_rid;
    logic [511:0] m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast;
    logic         m_axi_rvalid;
    logic         m_axi_rready;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tlast;
    logic         m_axis_tvalid;
    logic         m_axis_tready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_ring_reader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .base_addr     (base_addr),
        .wr_ptr        (wr_ptr),
        .rd_ptr        (rd_ptr),
        .rd_err        (rd_err),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arlock  (m_axi_arlock),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] pattern(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(i);
        return {16{w}};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_arvalid"}, 512'(m_axi_arvalid), 512'd0);
        check_eq({tag, "_rready"},  512'(m_axi_rready),  512'd0);
        check_eq({tag, "_tvalid"},  512'(m_axis_tvalid), 512'd0);
        check_eq({tag, "_rd_ptr"},  512'(rd_ptr),        512'd0);
        check_eq({tag, "_rd_err"},  512'(rd_err),        512'd0);
        check_eq({tag, "_araddr"},  512'(m_axi_araddr),  512'd0);
        check_eq({tag, "_tdata"},   m_axis_tdata,        512'd0);
    endtask

    // One complete ring-entry read: AR (held one cycle with arready low),
    // R with rvalid two cycles after R entry, OUT with tready held low
    // for 'hold' cycles.
    task automatic xfer(input int idx, input logic [511:0] data, input logic [1:0] resp,
                        input int hold);
        logic [33:0] exp_addr;
        bit          seen;
        exp_addr = base_addr + 34'(idx * 64);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (m_axi_arvalid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            check_eq("arvalid_timeout", 512'd0, 512'd1);
            return;
        end
        check_eq("araddr", 512'(m_axi_araddr), 512'(exp_addr));
        check_eq("arid", 512'(m_axi_arid), 512'd0);
        check_eq("rready_in_ar", 512'(m_axi_rready), 512'd0);
        tick();
        check_eq("arvalid_hold", 512'(m_axi_arvalid), 512'd1);
        check_eq("araddr_hold", 512'(m_axi_araddr), 512'(exp_addr));
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        check_eq("arvalid_clr", 512'(m_axi_arvalid), 512'd0);
        check_eq("rready_in_r", 512'(m_axi_rready), 512'd1);
        tick();
        tick();
        check_eq("rready_wait", 512'(m_axi_rready), 512'd1);
        check_eq("tvalid_pre", 512'(m_axis_tvalid), 512'd0);
        m_axi_rdata  = data;
        m_axi_rresp  = resp;
        m_axi_rvalid = 1'b1;
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = '0;
        m_axi_rresp  = 2'b00;
        check_eq("tvalid", 512'(m_axis_tvalid), 512'd1);
        check_eq("tdata", m_axis_tdata, data);
        check_eq("tlast", 512'(m_axis_tlast), 512'd1);
        check_eq("rready_out", 512'(m_axi_rready), 512'd0);
        for (int n = 0; n < hold; n++) begin
            tick();
            check_eq("tvalid_stall", 512'(m_axis_tvalid), 512'd1);
            check_eq("tdata_stall", m_axis_tdata, data);
            check_eq("arvalid_stall", 512'(m_axi_arvalid), 512'd0);
            check_eq("rd_ptr_stall", 512'(rd_ptr), 512'(idx));
        end
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        check_eq("tvalid_done", 512'(m_axis_tvalid), 512'd0);
        check_eq("rd_ptr_adv", 512'(rd_ptr), 512'((idx + 1) % 32));
    endtask

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b0;
        base_addr     = 34'h1000;
        wr_ptr        = 5'd0;
        m_axi_arready = 1'b0;
        m_axi_rid     = 6'd0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b1;
        m_axi_rvalid  = 1'b0;
        m_axis_tready = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        check_eq("arlen", 512'(m_axi_arlen), 512'd0);
        check_eq("arsize", 512'(m_axi_arsize), 512'd6);
        check_eq("arburst", 512'(m_axi_arburst), 512'd1);
        check_eq("arlock", 512'(m_axi_arlock), 512'd0);
        check_eq("arcache", 512'(m_axi_arcache), 512'd0);
        check_eq("arprot", 512'(m_axi_arprot), 512'd0);
        check_eq("tkeep", 512'(m_axis_tkeep), 512'(64'hFFFF_FFFF_FFFF_FFFF));
        rst_n = 1'b1;

        // Empty ring: nothing issued.
        enable = 1'b1;
        tick();
        tick();
        tick();
        check_eq("empty_idle", 512'(m_axi_arvalid), 512'd0);

        // Single entry at base 0x1000.
        wr_ptr = 5'd1;
        xfer(0, pattern(0), 2'b00, 0);
        tick();
        tick();
        check_eq("idle_after_one", 512'(m_axi_arvalid), 512'd0);
        check_eq("rd_ptr_one", 512'(rd_ptr), 512'd1);

        // Output back-pressure for 10 cycles.
        wr_ptr = 5'd2;
        xfer(1, pattern(1), 2'b00, 10);

        // SLVERR on entry 2, sticky through a later OKAY.
        wr_ptr = 5'd4;
        xfer(2, pattern(2), 2'b10, 0);
        check_eq("rd_err_set", 512'(rd_err), 512'd1);
        xfer(3, pattern(3), 2'b00, 0);
        check_eq("rd_err_sticky", 512'(rd_err), 512'd1);

        // wr_ptr=0 with rd_ptr=4: read 4..31, entry 31 at base+0x7C0, wrap to 0.
        wr_ptr = 5'd0;
        for (int i = 4; i < 31; i++) xfer(i, pattern(i), 2'b00, 0);
        check_eq("rd_ptr_31", 512'(rd_ptr), 512'd31);
        xfer(31, pattern(31), 2'b00, 0);
        check_eq("rd_ptr_wrap", 512'(rd_ptr), 512'd0);
        for (int n = 0; n < 5; n++) tick();
        check_eq("idle_after_wrap", 512'(m_axi_arvalid), 512'd0);
        check_eq("rd_err_still", 512'(rd_err), 512'd1);

        // Reset while in R.
        wr_ptr = 5'd1;
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 20; n++) begin
                if (m_axi_arvalid) begin
                    seen = 1'b1;
                    break;
                end
                tick();
            end
            check_eq("arvalid_pre_rst", 512'(seen), 512'd1);
        end
        check_eq("araddr_pre_rst", 512'(m_axi_araddr), 512'h1000);
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        check_eq("rready_pre_rst", 512'(m_axi_rready), 512'd1);
        m_axi_rdata  = pattern(99);
        m_axi_rvalid = 1'b1;
        rst_n        = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        check_reset_outputs("midrst_hold");
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = '0;
        wr_ptr       = 5'd3;
        rst_n        = 1'b1;
        xfer(0, pattern(40), 2'b00, 0);
        xfer(1, pattern(41), 2'b00, 0);
        xfer(2, pattern(42), 2'b00, 0);
        for (int n = 0; n < 5; n++) tick();
        check_eq("idle_after_rst", 512'(m_axi_arvalid), 512'd0);
        check_eq("rd_ptr_final", 512'(rd_ptr), 512'd3);
        check_eq("rd_err_final", 512'(rd_err), 512'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_ring_reader.md
AXI_RING_READER -- requirements
Module: axi_ring_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, AXI/AXIS data width in bits.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, strobe/keep width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 34, AXI address width.
REQ-004 SHALL have parameter ID_WIDTH, default 6, AXI ID width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 32, number of DATA_WIDTH-bit ring entries.
REQ-006 SHALL have port clk  input  1  the single clock.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port enable  input  1  level; permits new reads.
REQ-009 SHALL have port base_addr  input  ADDR_WIDTH  byte address of ring entry 0.
REQ-010 SHALL have port wr_ptr  input  PTR_WIDTH  producer index, one past the last valid entry.
REQ-011 SHALL have port rd_ptr  output  PTR_WIDTH  consumer index, the next entry to read.
REQ-012 SHALL have port rd_err  output  1  sticky flag, set on any nonzero rresp.
REQ-013 SHALL have ports m_axi_arid (ID_WIDTH) and m_axi_araddr (ADDR_WIDTH), both outputs.
REQ-014 SHALL drive these constant outputs: m_axi_arlen=0, arsize=log2(KEEP_WIDTH), arburst=INCR(1), arlock=0, arcache=0, arprot=0.
REQ-015 SHALL have port m_axi_arvalid output 1 and port m_axi_arready input 1.
REQ-016 SHALL have ports m_axi_rdata (DATA_WIDTH) and m_axi_rresp (2), both inputs.
REQ-017 SHALL have ports m_axi_rid and m_axi_rlast, both inputs and both ignored.
REQ-018 SHALL have port m_axi_rvalid input 1 and port m_axi_rready output 1.
REQ-019 SHALL have ports m_axis_tdata (DATA_WIDTH), m_axis_tkeep (all ones), m_axis_tlast (constant 1), all outputs.
REQ-020 SHALL have port m_axis_tvalid output 1 and port m_axis_tready input 1.

Function
REQ-021 SHALL define PTR_WIDTH=$clog2(FIFO_DEPTH); ring is empty iff rd_ptr==wr_ptr; rd_ptr wraps FIFO_DEPTH-1 -> 0.
REQ-022 SHALL run a four-state FSM: IDLE, AR, R, OUT.
REQ-023 SHALL go IDLE->AR when enable && !empty, latching m_axi_araddr = base_addr + rd_ptr*KEEP_WIDTH (mod 2^ADDR_WIDTH); arvalid rises in the following cycle.
REQ-024 SHALL hold arvalid and araddr stable in AR until arready, then clear arvalid and enter R.
REQ-025 SHALL assert rready only in R; on rvalid, register rdata into tdata, set tvalid, OR (rresp!=0) into rd_err, and enter OUT.
REQ-026 SHALL hold tdata/tvalid stable in OUT until tready, then clear tvalid, advance rd_ptr with wrap, and return to IDLE.
REQ-027 SHALL keep at most one read outstanding; m_axi_arid is constant 0.
REQ-028 SHALL forward data from an error response and advance rd_ptr as normal.
REQ-029 SHALL always complete the transaction in flight when enable falls mid-transaction, then wait in IDLE.
REQ-030 SHALL ignore changes to base_addr and wr_ptr outside IDLE; in IDLE, empty is evaluated from the registered rd_ptr.

Reset
REQ-031 SHALL, while rst_n=0, force state=IDLE, rd_ptr=0, rd_err=0, arvalid=0, rready=0, tvalid=0, araddr=0, tdata=0.
REQ-032 SHALL abandon any transaction on reset mid-operation, with no further AXI handshake.

Structure
REQ-033 SHALL place FSM state encodings and the AXI burst/size constants in the shared package axi_ctrl_pkg.
REQ-034 SHALL be a single flat module with no sub-modules.

Verification
REQ-035 Check: base=0x1000, wr_ptr 0->1, arready=1, rvalid after 2 cycles -> araddr=0x1000, one tvalid beat with tlast=1, rd_ptr=1.
REQ-036 Check: rd_ptr=31, wr_ptr=0 (FIFO_DEPTH=32) -> araddr=base+0x7C0, then rd_ptr wraps to 0 and FSM idles.
REQ-037 Check: tready held low 10 cycles -> tvalid and tdata stable, no new arvalid, rd_ptr unchanged.
REQ-038 Check: rresp=2 on one entry -> data forwarded, rd_err=1 and stays 1 across later OKAY responses.
REQ-039 Check: rst_n low while in R -> all outputs at reset values next edge; after release with wr_ptr=3, reads entries 0,1,2.
